byte_frame_serializer: RTL and testbench
========================================

Name: byte_frame_serializer

Overview:
- Downstream stage of the round-robin arbiter; consumes its byte stream (dout/valid) and drives it off-chip on a single serial line.
- Buffers bytes in a small FIFO and frames each one as start bit, 8 data bits MSB-first, stop bit.
- Flags any byte lost because the FIFO was full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- BIT_CYCLES, 2, clock cycles each serial bit is held; at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- din  input  8  byte from the arbiter's dout.
- din_valid  input  1  din is valid this cycle; driven by the arbiter's valid.
- ser_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- fifo_count  output  $clog2(DEPTH)+1  bytes currently stored.
- overflow  output  1  sticky: at least one byte has been dropped.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while rst=1, all state is forced immediately, with no clock edge needed:
  - ser_out=1, busy=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE; FIFO pointers, bit counter and cycle counter are cleared.
  - A frame in progress when reset asserts is abandoned; it does not resume.
- Write:
  - A byte is accepted at an edge where din_valid=1 and the FIFO is not full.
  - The FIFO also counts as not full if a pop occurs at the same edge.
  - If din_valid=1 at an edge where the FIFO is full and no pop occurs, the byte is dropped and overflow is set to 1. overflow stays 1 until reset.
- FSM states:
  - IDLE: ser_out=1, busy=0. At an edge with fifo_count>0, the FIFO head is popped into an 8-bit shift register and the FSM goes to START.
  - START: ser_out=0 for BIT_CYCLES cycles, then goes to DATA.
  - DATA: 8 bits, bit 7 first. Each bit is held BIT_CYCLES cycles. A 3-bit counter tracks bit position and wraps 7->0 on the exit to STOP.
  - STOP: ser_out=1 for BIT_CYCLES cycles. On its last cycle:
    - if fifo_count>0 (evaluated before any same-edge write), pop and go straight to START with no idle gap;
    - otherwise go to IDLE.
- Outputs: all registered. busy=1 in START, DATA and STOP.
- Frame timing:
  - One frame is 10*BIT_CYCLES cycles.
  - Back-to-back frames repeat with period 10*BIT_CYCLES.
- Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. The first start-bit cycle starts at edge k+1.
- fifo_count:
  - A write and a pop at the same edge leave the count unchanged.
  - The count never exceeds DEPTH and never underflows.
- Pointers: wrap modulo DEPTH.
- Don't-care input: din is ignored when din_valid=0; X on din in that case must not propagate.

Test Plan:
- Reset then idle: rst pulse with no din_valid -> ser_out=1, busy=0, fifo_count=0, overflow=0 held for 20 cycles.
- Single byte, BIT_CYCLES=2: din=8'hA5 with din_valid for 1 cycle.
  - ser_out sequence is 0,1,0,1,0,0,1,0,1,1, each value held 2 cycles, starting at the next edge.
  - busy is high for exactly 20 cycles, then the line returns to idle.
- Back-to-back burst: din=10,20,30,40 on 4 consecutive cycles.
  - Four contiguous frames, 80 busy cycles, no idle gap.
  - Bytes appear in order.
  - fifo_count peaks at 3 and ends at 0.
  - overflow stays 0.
- Overflow: 6 consecutive valid bytes 1..6 with DEPTH=4.
  - Byte 1 is popped immediately.
  - Bytes 2..5 fill the FIFO (fifo_count=4).
  - Byte 6 is dropped; overflow=1 from that edge onward.
  - Exactly 5 frames are sent.
- Simultaneous push/pop at full: keep the FIFO full and write one byte at the STOP->START edge.
  - The byte is accepted and fifo_count stays at DEPTH.
  - overflow is unchanged.
- Reset mid-frame: assert rst asynchronously (between edges) during DATA bit 3.
  - ser_out=1, busy=0, fifo_count=0 and overflow=0 immediately.
  - After release, a new byte 8'h3C transmits correctly.

Source files
------------

// File: rtl/byte_frame_serializer.sv
// Frames queued bytes as start bit, 8 data bits MSB-first and stop bit on one serial line.
// First start bit follows a write by one edge; a byte arriving at a full FIFO with no pop is dropped and flagged.

module byte_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

module byte_frame_serializer #(
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic                     ser_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST_CYC = CW'(BIT_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cyc;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_ser;
  logic            r_busy;
  logic            r_ovf;

  logic            w_has_data;
  logic            w_bit_end;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic [7:0]      w_head;
  logic [CNTW-1:0] w_count;

  assign w_has_data = (w_count != '0);
  assign w_bit_end  = (r_cyc == LAST_CYC);
  assign w_full     = (w_count == FULL_CNT);
  // A pop on the last stop cycle chains the next frame with no idle gap.
  assign w_pop      = w_has_data && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  assign w_push     = din_valid && (!w_full || w_pop);

  byte_frame_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (din_valid && w_full && !w_pop) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_cyc   <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_ser   <= r_shift[7];
            r_shift <= {r_shift[6:0], 1'b0};
            r_state <= DATA;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_ser   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_ser   <= r_shift[7];
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_ser   <= 1'b0;
              r_state <= START;
            end else begin
              r_ser   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_out    = r_ser;
  assign busy       = r_busy;
  assign fifo_count = w_count;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_byte_frame_serializer.sv
// Bench for byte_frame_serializer: table-driven single frames, line decoder with byte scoreboard, corner sequences.
module tb_byte_frame_serializer;
  localparam int DEPTH      = 4;
  localparam int BIT_CYCLES = 2;
  localparam int CNTW       = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      din;
  logic            din_valid;
  logic            ser_out;
  logic            busy;
  logic [CNTW-1:0] fifo_count;
  logic            overflow;

  int n_cmp    = 0;
  int n_err    = 0;
  int n_frames = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;  // start bit in [9], stop bit in [0]
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  byte_frame_serializer #(.DEPTH(DEPTH), .BIT_CYCLES(BIT_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .ser_out    (ser_out),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line decoder: sampled on negedges, second cycle of each bit.
  initial begin : line_monitor
    logic [7:0] b;
    logic       st;
    logic       sp;
    logic       abort;
    forever begin
      @(negedge clk);
      if (!rst && ser_out === 1'b0) begin
        abort = 1'b0;
        @(negedge clk); abort |= rst; st = ser_out;
        for (int i = 7; i >= 0; i--) begin
          @(negedge clk); abort |= rst;
          @(negedge clk); abort |= rst;
          b[i] = ser_out;
        end
        @(negedge clk); abort |= rst;
        @(negedge clk); abort |= rst;
        sp = ser_out;
        if (!abort) begin
          chk("start_bit", {31'd0, st}, 32'd0);
          chk("stop_bit", {31'd0, sp}, 32'd1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got byte %0h, required no frame", b);
          end else begin
            chk("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
          n_frames++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    din_valid = 1'b0;
    din       = 'x;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    din_valid = 1'b0;
    din       = 'x;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, (k < budget)}, 32'd1);
  endtask

  initial begin : main
    vec_t t;
    int frames0;
    int maxc;
    int nbusy;
    int first;
    int last;
    logic ovf_seen;

    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h3C, 10'b0001111001};
    vecs[2] = '{8'h00, 10'b0000000001};
    vecs[3] = '{8'hFF, 10'b0111111111};
    vecs[4] = '{8'h81, 10'b0100000011};

    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("idle_ser",  {31'd0, ser_out}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_cnt",  {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
      chk("idle_ovf",  {31'd0, overflow}, 32'd0);
      @(negedge clk);
    end

    // Single frames from the table
    for (int v = 0; v < 5; v++) begin
      t = vecs[v];
      din = t.din; din_valid = 1'b1; exp_q.push_back(t.din);
      @(negedge clk);
      drive_idle();
      chk("lat_cnt",  {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
      chk("lat_ser",  {31'd0, ser_out}, 32'd1);
      chk("lat_busy", {31'd0, busy}, 32'd0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        chk("frame_ser",  {31'd0, ser_out}, {31'd0, t.frame[9 - c/2]});
        chk("frame_busy", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_ser",  {31'd0, ser_out}, 32'd1);
      wait_drain("vec_drain", 10);
    end

    // Back-to-back burst
    do_reset();
    frames0 = n_frames; maxc = 0; nbusy = 0; first = -1; last = -1; ovf_seen = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (busy) begin
        nbusy++;
        if (first < 0) first = i;
        last = i;
      end
      if (overflow) ovf_seen = 1'b1;
      if (i < 4) begin
        din = 8'(10 * (i + 1)); din_valid = 1'b1; exp_q.push_back(din);
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
    chk("burst_busy_cycles", nbusy, 80);
    chk("burst_contiguous", last - first + 1, 80);
    chk("burst_peak_cnt", maxc, 3);
    chk("burst_end_cnt", {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
    chk("burst_ovf", {31'd0, ovf_seen}, 32'd0);
    chk("burst_frames", n_frames - frames0, 4);
    chk("burst_queue", exp_q.size(), 0);

    // Overflow: sixth byte is dropped
    do_reset();
    frames0 = n_frames;
    for (int i = 0; i < 120; i++) begin
      if (i == 2) begin
        chk("ovf_first_popped", {31'd0, busy}, 32'd1);
        chk("ovf_cnt_i2", {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
      end
      if (i == 5) begin
        chk("ovf_full_cnt", {{(32-CNTW){1'b0}}, fifo_count}, 32'd4);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
      end
      if (i == 6) begin
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_cnt_after", {{(32-CNTW){1'b0}}, fifo_count}, 32'd4);
      end
      if (i < 6) begin
        din = 8'(i + 1); din_valid = 1'b1;
        if (i < 5) exp_q.push_back(din);
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
    chk("ovf_frames", n_frames - frames0, 5);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_queue", exp_q.size(), 0);

    // Push and pop at the same edge while full
    do_reset();
    frames0 = n_frames;
    for (int i = 0; i < 140; i++) begin
      if (i == 21) chk("full_pre_cnt", {{(32-CNTW){1'b0}}, fifo_count}, 32'd4);
      if (i == 22) begin
        chk("full_pushpop_cnt", {{(32-CNTW){1'b0}}, fifo_count}, 32'd4);
        chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
      end
      if (i < 5) begin
        din = 8'hB0 + 8'(i); din_valid = 1'b1; exp_q.push_back(din);
      end else if (i == 21) begin
        din = 8'hC6; din_valid = 1'b1; exp_q.push_back(din);
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
    chk("full_frames", n_frames - frames0, 6);
    chk("full_end_ovf", {31'd0, overflow}, 32'd0);
    chk("full_queue", exp_q.size(), 0);

    // Asynchronous reset during data bit 3
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        din = 8'(17 * i); din_valid = 1'b1;
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
    chk("mid_pre_ser",  {31'd0, ser_out}, 32'd0);
    chk("mid_pre_busy", {31'd0, busy}, 32'd1);
    chk("mid_pre_cnt",  {{(32-CNTW){1'b0}}, fifo_count}, 32'd4);
    chk("mid_pre_ovf",  {31'd0, overflow}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ser",  {31'd0, ser_out}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cnt",  {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
    chk("mid_rst_ovf",  {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    chk("mid_after_busy", {31'd0, busy}, 32'd0);
    chk("mid_after_ser", {31'd0, ser_out}, 32'd1);
    frames0 = n_frames;
    din = 8'h3C; din_valid = 1'b1; exp_q.push_back(din);
    @(negedge clk);
    drive_idle();
    wait_drain("mid_drain", 40);
    @(negedge clk);
    chk("mid_frames", n_frames - frames0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
